// File: rtl/datapath_pkg.sv
// Shared definitions for the datapath: control-word layout, ALU opcodes and flag bit indices.
package datapath_pkg;

    localparam int unsigned CTRL_W       = 16;
    localparam int unsigned OP_W         = 3;
    localparam int unsigned SEL_W        = 4;
    localparam int unsigned FLAGS_W      = 4;

    localparam int unsigned CTRL_OP_LSB  = 13;
    localparam int unsigned CTRL_A_LSB   = 9;
    localparam int unsigned CTRL_B_LSB   = 5;
    localparam int unsigned CTRL_DST_LSB = 1;
    localparam int unsigned CTRL_WE_BIT  = 0;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [OP_W-1:0] {
        ALU_PASS = 3'b000,
        ALU_ADD  = 3'b001,
        ALU_SUB  = 3'b010,
        ALU_AND  = 3'b011,
        ALU_OR   = 3'b100,
        ALU_XOR  = 3'b101,
        ALU_SHL  = 3'b110,
        ALU_SHR  = 3'b111
    } alu_op_e;

    typedef struct packed {
        alu_op_e          op;
        logic [SEL_W-1:0] sel_a;
        logic [SEL_W-1:0] sel_b;
        logic [SEL_W-1:0] sel_dst;
        logic             we;
    } ctrl_t;

endpackage

// File: rtl/rf_2r1w.sv
// Register file: two asynchronous read ports, one synchronous write port, whole array exported for debug.
module rf_2r1w
    import datapath_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NREGS  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [SEL_W-1:0]               rd_addr_a,
    output logic [DATA_W-1:0]              rd_data_a,
    input  logic [SEL_W-1:0]               rd_addr_b,
    output logic [DATA_W-1:0]              rd_data_b,
    input  logic                           wr_en,
    input  logic [SEL_W-1:0]               wr_addr,
    input  logic [DATA_W-1:0]              wr_data,
    output logic [NREGS-1:0][DATA_W-1:0]   regs
);

    localparam int unsigned IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [NREGS-1:0][DATA_W-1:0] mem;

    logic valid_a;
    logic valid_b;
    logic valid_w;

    // Out-of-range indices read as zero and never write.
    assign valid_a = 32'(rd_addr_a) < NREGS;
    assign valid_b = 32'(rd_addr_b) < NREGS;
    assign valid_w = 32'(wr_addr) < NREGS;

    assign rd_data_a = valid_a ? mem[rd_addr_a[IDX_W-1:0]] : '0;
    assign rd_data_b = valid_b ? mem[rd_addr_b[IDX_W-1:0]] : '0;
    assign regs      = mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
        end else if (wr_en && valid_w) begin
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/datapath_rf_alu.sv
// Two-stage datapath: RF operand fetch, ALU with N/Z/C/V flags, and write-back shared with an external load port.
module datapath_rf_alu
    import datapath_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NREGS  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CTRL_W-1:0]    ctrl,
    input  logic                 ld_en,
    input  logic [SEL_W-1:0]     ld_addr,
    input  logic [DATA_W-1:0]    ld_data,
    input  logic [SEL_W-1:0]     dbg_addr,
    output logic [DATA_W-1:0]    dbg_data,
    output logic [DATA_W-1:0]    result,
    output logic [FLAGS_W-1:0]   flags,
    output logic                 wr_conflict
);

    localparam int unsigned IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int unsigned MSB   = DATA_W - 1;

    ctrl_t                        c;
    logic [DATA_W-1:0]            rd_a;
    logic [DATA_W-1:0]            rd_b;
    logic [NREGS-1:0][DATA_W-1:0] regs;
    logic                         wr_en;
    logic [SEL_W-1:0]             wr_addr;
    logic [DATA_W-1:0]            wr_data;

    logic [DATA_W-1:0]            op_a_q;
    logic [DATA_W-1:0]            op_b_q;
    alu_op_e                      op_q;
    logic [DATA_W-1:0]            result_q;
    logic [FLAGS_W-1:0]           flags_q;

    logic [DATA_W:0]              wide;
    logic [DATA_W-1:0]            alu_res;
    logic                         alu_c;
    logic                         alu_v;
    logic [FLAGS_W-1:0]           flags_d;

    always_comb begin
        c         = '0;
        c.op      = alu_op_e'(ctrl[CTRL_OP_LSB +: OP_W]);
        c.sel_a   = ctrl[CTRL_A_LSB +: SEL_W];
        c.sel_b   = ctrl[CTRL_B_LSB +: SEL_W];
        c.sel_dst = ctrl[CTRL_DST_LSB +: SEL_W];
        c.we      = ctrl[CTRL_WE_BIT];
    end

    // Single write port: the external load always wins over ALU write-back.
    assign wr_en       = ld_en | c.we;
    assign wr_addr     = ld_en ? ld_addr : c.sel_dst;
    assign wr_data     = ld_en ? ld_data : result_q;
    assign wr_conflict = ~rst & ld_en & c.we;

    rf_2r1w #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_rf (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (c.sel_a),
        .rd_data_a (rd_a),
        .rd_addr_b (c.sel_b),
        .rd_data_b (rd_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .regs      (regs)
    );

    assign dbg_data = (32'(dbg_addr) < NREGS) ? regs[dbg_addr[IDX_W-1:0]] : '0;

    // ALU evaluated one bit wider so carry/borrow/shift-out fall into bit DATA_W.
    always_comb begin
        wide  = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (op_q)
            ALU_PASS: wide = {1'b0, op_a_q};
            ALU_ADD: begin
                wide  = {1'b0, op_a_q} + {1'b0, op_b_q};
                alu_c = wide[DATA_W];
                alu_v = (op_a_q[MSB] == op_b_q[MSB]) && (wide[MSB] != op_a_q[MSB]);
            end
            ALU_SUB: begin
                wide  = {1'b0, op_a_q} - {1'b0, op_b_q};
                alu_c = wide[DATA_W];
                alu_v = (op_a_q[MSB] != op_b_q[MSB]) && (wide[MSB] != op_a_q[MSB]);
            end
            ALU_AND: wide = {1'b0, op_a_q & op_b_q};
            ALU_OR:  wide = {1'b0, op_a_q | op_b_q};
            ALU_XOR: wide = {1'b0, op_a_q ^ op_b_q};
            ALU_SHL: begin
                wide  = {op_a_q, 1'b0};
                alu_c = wide[DATA_W];
            end
            ALU_SHR: begin
                wide  = {2'b00, op_a_q[MSB:1]};
                alu_c = op_a_q[0];
            end
            default: wide = '0;
        endcase
        alu_res         = wide[DATA_W-1:0];
        flags_d         = '0;
        flags_d[FLAG_N] = alu_res[MSB];
        flags_d[FLAG_Z] = (alu_res == '0);
        flags_d[FLAG_C] = alu_c;
        flags_d[FLAG_V] = alu_v;
    end

    // Operand fetch and result/flag stages; free-running every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_q     <= ALU_PASS;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            op_a_q   <= rd_a;
            op_b_q   <= rd_b;
            op_q     <= c.op;
            result_q <= alu_res;
            flags_q  <= flags_d;
        end
    end

    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_datapath_rf_alu.sv
// Directed bench for datapath_rf_alu with hand-computed results and flags.
module tb_datapath_rf_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ctrl;
    logic        ld_en;
    logic [3:0]  ld_addr;
    logic [7:0]  ld_data;
    logic [3:0]  dbg_addr;
    logic [7:0]  dbg_data;
    logic [7:0]  result;
    logic [3:0]  flags;
    logic        wr_conflict;

    int n_chk = 0;
    int n_bad = 0;

    datapath_rf_alu #(.DATA_W(8), .NREGS(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .ctrl        (ctrl),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .result      (result),
        .flags       (flags),
        .wr_conflict (wr_conflict)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [3:0] a,
                                       input logic [3:0] b, input logic [3:0] dst,
                                       input logic we);
        return {op, a, b, dst, we};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] addr, input logic [7:0] data);
        ld_en   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        step();
        ld_en   = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [3:0] addr, input logic [7:0] exp);
        dbg_addr = addr;
        #1;
        check(tag, dbg_data, exp);
    endtask

    // Issue one op, wait the two pipeline stages, check result and {N,Z,C,V}.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [3:0] a,
                          input logic [3:0] b, input logic [7:0] exp_r, input logic [3:0] exp_f);
        ctrl = mk(op, a, b, 4'd0, 1'b0);
        step();
        step();
        check({tag, "_res"}, result, exp_r);
        check({tag, "_flg"}, flags, exp_f);
        ctrl = 16'h0;
    endtask

    initial begin
        rst      = 1'b1;
        ctrl     = 16'h0;
        ld_en    = 1'b0;
        ld_addr  = 4'd0;
        ld_data  = 8'd0;
        dbg_addr = 4'd0;
        #1;
        check("rst_result", result, 8'h00);
        check("rst_flags", flags, 4'h0);
        check("rst_conflict", wr_conflict, 1'b0);
        step();
        rst = 1'b0;

        // ADD 5+3, then write back into R2
        load(4'd0, 8'h05);
        load(4'd1, 8'h03);
        ctrl = mk(3'b001, 4'd0, 4'd1, 4'd0, 1'b0);
        step();
        step();
        check("add_res", result, 8'h08);
        check("add_flg", flags, 4'b0000);
        ctrl = mk(3'b001, 4'd0, 4'd1, 4'd2, 1'b1);
        step();
        ctrl = 16'h0;
        check_reg("wb_r2", 4'd2, 8'h08);

        load(4'd5, 8'h7F);
        load(4'd6, 8'h01);
        load(4'd7, 8'h81);
        load(4'd8, 8'hFF);
        run_op("add_ovf",  3'b001, 4'd5, 4'd6, 8'h80, 4'b1001);
        run_op("sub_neg",  3'b010, 4'd1, 4'd0, 8'hFE, 4'b1010);
        run_op("sub_zero", 3'b010, 4'd0, 4'd0, 8'h00, 4'b0100);
        run_op("add_cy",   3'b001, 4'd8, 4'd6, 8'h00, 4'b0110);
        run_op("and",      3'b011, 4'd0, 4'd1, 8'h01, 4'b0000);
        run_op("or",       3'b100, 4'd0, 4'd1, 8'h07, 4'b0000);
        run_op("xor",      3'b101, 4'd0, 4'd1, 8'h06, 4'b0000);
        run_op("shl",      3'b110, 4'd5, 4'd0, 8'hFE, 4'b1000);
        run_op("shl_c",    3'b110, 4'd7, 4'd0, 8'h02, 4'b0010);
        run_op("shr_c",    3'b111, 4'd7, 4'd0, 8'h40, 4'b0010);
        run_op("shr",      3'b111, 4'd1, 4'd0, 8'h01, 4'b0010);
        run_op("pass",     3'b000, 4'd8, 4'd0, 8'hFF, 4'b1000);

        // Load and ctrl write collide: load wins, R4 keeps its value
        load(4'd4, 8'h55);
        ld_en   = 1'b1;
        ld_addr = 4'd3;
        ld_data = 8'hAA;
        ctrl    = mk(3'b000, 4'd0, 4'd0, 4'd4, 1'b1);
        #1;
        check("conflict_hi", wr_conflict, 1'b1);
        step();
        ld_en = 1'b0;
        ctrl  = 16'h0;
        #1;
        check("conflict_lo", wr_conflict, 1'b0);
        check_reg("conflict_r3", 4'd3, 8'hAA);
        check_reg("conflict_r4", 4'd4, 8'h55);

        // Read and write of R2 in the same cycle returns the old value
        ld_en   = 1'b1;
        ld_addr = 4'd2;
        ld_data = 8'h3C;
        ctrl    = mk(3'b000, 4'd2, 4'd0, 4'd0, 1'b0);
        step();
        ld_en = 1'b0;
        step();
        check("rw_old", result, 8'h08);
        step();
        check("rw_new", result, 8'h3C);
        ctrl = 16'h0;

        // Asynchronous reset mid-run with a nonzero result in flight
        ctrl = mk(3'b001, 4'd0, 4'd1, 4'd0, 1'b0);
        step();
        step();
        check("pre_rst_res", result, 8'h08);
        rst = 1'b1;
        #1;
        check("mid_rst_res", result, 8'h00);
        check("mid_rst_flg", flags, 4'h0);
        for (int i = 0; i < 16; i++) begin
            check_reg($sformatf("mid_rst_r%0d", i), 4'(i), 8'h00);
        end
        step();
        rst = 1'b0;
        step();
        step();
        check("post_rst_res", result, 8'h00);
        check("post_rst_flg", flags, 4'b0100);
        ctrl = 16'h0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
